// File: rtl/uart_mmio_fifo.sv
// MMIO UART buffering stage: TX/RX byte FIFOs behind a CPU load/store window.
// Optional sticky error register at offset 0x0C is built when UART_MMIO_ERR_EN is defined.
module uart_mmio_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic       in_win;
    logic [7:0] offset;
    logic       rd_status, rd_rx, wr_tx;
    logic       tx_full, tx_empty, tx_push, tx_pop;
    logic       rx_full, rx_empty, rx_push, rx_pop;

    assign in_win    = (cpu_addr[31:8] == ADDR_BASE[31:8]);
    assign offset    = cpu_addr[7:0];
    assign rd_status = cpu_rd_en && in_win && (offset == 8'h00);
    assign rd_rx     = cpu_rd_en && in_win && (offset == 8'h04);
    assign wr_tx     = cpu_wr_en && in_win && (offset == 8'h08);

    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    // Full is judged on the start-of-cycle count, so a store into a full FIFO
    // is dropped even when the UART drains an entry in the same cycle.
    assign tx_push = wr_tx && !tx_full;
    assign tx_pop  = !tx_empty && uart_tx_ready;
    assign rx_push = uart_rx_valid && uart_rx_ready;
    assign rx_pop  = rd_rx && !rx_empty;

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_mem[tx_rd_ptr_q];
    assign uart_rx_ready = rst && !rx_full;
    assign cpu_rdata     = rdata_q;

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

`ifdef UART_MMIO_ERR_EN
    logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic rd_err, wr_err;

    assign rd_err = cpu_rd_en && in_win && (offset == 8'h0C);
    assign wr_err = cpu_wr_en && in_win && (offset == 8'h0C);

    // W1C clear first, then the set event, so a coincident event wins.
    always_comb begin
        tx_ovf_d = (tx_ovf_q && !(wr_err && cpu_wdata[0])) || (wr_tx && tx_full);
        rx_udf_d = (rx_udf_q && !(wr_err && cpu_wdata[1])) || (rd_rx && rx_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        if (rd_status) begin
            rdata_d = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 6'b0, !rx_empty, !tx_full};
        end else if (rd_rx && !rx_empty) begin
            rdata_d = {24'b0, rx_mem[rx_rd_ptr_q]};
        end
`ifdef UART_MMIO_ERR_EN
        else if (rd_err) begin
            rdata_d = {30'b0, rx_udf_q, tx_ovf_q};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            rdata_q     <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage needs no reset: the counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= cpu_wdata;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= uart_rx_data;
    end
endmodule
